hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS core.
- Drives PC/IF-ID write enables and IF-ID/ID-EXE flushes, plus a global pipe_en freeze for a stalled data memory.
- Generates rs/rt forward-mux selects for ID->EXE.
- Sequences the multi-cycle mul/div unit using an internal busy state machine and counter.

---
 rtl/hazard_ctrl.sv | 99 +++++++++
 tb/tb_hazard_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control for the 5-stage MIPS pipeline,
// including mul/div sequencing and data-memory freeze with timeout.
module hazard_ctrl #(
  parameter int MUL_CYCLES  = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       exe_wb_we,
  input  logic [4:0] exe_wb_dreg,
  input  logic       exe_is_load,
  input  logic       mem_wb_we,
  input  logic [4:0] mem_wb_dreg,
  input  logic       branch_taken,
  input  logic       md_start,
  input  logic       md_is_div,
  input  logic       id_md_read,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       if_id_we,
  output logic       if_id_flush,
  output logic       id_exe_flush,
  output logic       pipe_en,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       md_busy,
  output logic       md_done,
  output logic       mem_err
);
  localparam int MAXC = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] md_cnt_q, md_cnt_d;
  logic [7:0]    wait_cnt_q, wait_cnt_d;
  logic          freeze_req, timeout, freeze, load_use, md_hold, stall, accept;
  logic          exe_ok, mem_ok;

  // A load in EXE has no result yet, so it never forwards from EXE.
  assign exe_ok = exe_wb_we && exe_wb_dreg != 5'd0 && !exe_is_load;
  assign mem_ok = mem_wb_we && mem_wb_dreg != 5'd0;

  assign fwd_a_sel = (!rst_n || !id_use_rs) ? 2'b00 :
                     (exe_ok && exe_wb_dreg == id_rs) ? 2'b10 :
                     (mem_ok && mem_wb_dreg == id_rs) ? 2'b01 : 2'b00;
  assign fwd_b_sel = (!rst_n || !id_use_rt) ? 2'b00 :
                     (exe_ok && exe_wb_dreg == id_rt) ? 2'b10 :
                     (mem_ok && mem_wb_dreg == id_rt) ? 2'b01 : 2'b00;

  always_comb begin
    freeze_req = mem_req && !mem_ready;
    timeout    = freeze_req && wait_cnt_q == 8'(MEM_TIMEOUT - 1);
    freeze     = freeze_req && !timeout;
    load_use   = exe_is_load && exe_wb_we && exe_wb_dreg != 5'd0 &&
                 ((id_use_rs && id_rs == exe_wb_dreg) || (id_use_rt && id_rt == exe_wb_dreg));
    md_hold    = state_q == BUSY && (id_md_read || md_start);
    stall      = load_use || md_hold;
    accept     = state_q == IDLE && md_start && !load_use && !freeze;
    wait_cnt_d = freeze ? wait_cnt_q + 8'd1 : 8'd0;
    state_d    = state_q;
    md_cnt_d   = md_cnt_q;
    if (accept) begin
      state_d  = BUSY;
      md_cnt_d = md_is_div ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);
    end else if (state_q == BUSY && !freeze) begin
      state_d  = (md_cnt_q == '0) ? IDLE : BUSY;
      md_cnt_d = (md_cnt_q == '0) ? md_cnt_q : md_cnt_q - CW'(1);
    end
    // Outputs are gated by rst_n so the reset values appear without waiting for a clock.
    pc_we        = rst_n && !freeze && !stall;
    if_id_we     = rst_n && !freeze && !stall;
    id_exe_flush = !rst_n || (!freeze && stall);
    if_id_flush  = !rst_n || (!freeze && !stall && branch_taken);
    pipe_en      = rst_n && !freeze;
    md_busy      = rst_n && state_q == BUSY;
    md_done      = rst_n && state_q == BUSY && md_cnt_q == '0 && !freeze;
    mem_err      = rst_n && timeout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      md_cnt_q   <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      md_cnt_q   <= md_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench; a cycle-level reference model queues the
// expected outputs, a negedge monitor pops and compares them.
module tb_hazard_ctrl;
  localparam int MUL = 4;
  localparam int DIV = 32;
  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, exe_wb_dreg = '0, mem_wb_dreg = '0;
  logic       id_use_rs = 0, id_use_rt = 0, exe_wb_we = 0, exe_is_load = 0, mem_wb_we = 0;
  logic       branch_taken = 0, md_start = 0, md_is_div = 0, id_md_read = 0;
  logic       mem_req = 0, mem_ready = 1;
  logic       pc_we, if_id_we, if_id_flush, id_exe_flush, pipe_en, md_busy, md_done, mem_err;
  logic [1:0] fwd_a_sel, fwd_b_sel;

  always #5 clk = ~clk;

  hazard_ctrl #(.MUL_CYCLES(MUL), .DIV_CYCLES(DIV), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .exe_wb_we(exe_wb_we),
    .exe_wb_dreg(exe_wb_dreg), .exe_is_load(exe_is_load), .mem_wb_we(mem_wb_we),
    .mem_wb_dreg(mem_wb_dreg), .branch_taken(branch_taken), .md_start(md_start),
    .md_is_div(md_is_div), .id_md_read(id_md_read), .mem_req(mem_req),
    .mem_ready(mem_ready), .pc_we(pc_we), .if_id_we(if_id_we),
    .if_id_flush(if_id_flush), .id_exe_flush(id_exe_flush), .pipe_en(pipe_en),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .md_busy(md_busy),
    .md_done(md_done), .mem_err(mem_err)
  );

  typedef struct {
    logic       rst_n;
    logic [4:0] rs, rt, exe_d, mem_d;
    logic       use_rs, use_rt, exe_we, load, mem_we;
    logic       br, start, is_div, md_read, req, rdy;
  } stim_t;

  typedef logic [11:0] out_t;

  stim_t s;
  out_t  exp_q[$];
  int    n_cmp = 0, n_bad = 0, cyc = 0;
  int    md_left = 0, wait_run = 0, md_left_n = 0, wait_run_n = 0;

  function automatic stim_t idle_s();
    stim_t t;
    t.rst_n = 1; t.rs = 0; t.rt = 0; t.exe_d = 0; t.mem_d = 0;
    t.use_rs = 0; t.use_rt = 0; t.exe_we = 0; t.load = 0; t.mem_we = 0;
    t.br = 0; t.start = 0; t.is_div = 0; t.md_read = 0; t.req = 0; t.rdy = 1;
    return t;
  endfunction

  function automatic logic [1:0] ref_fwd(input logic u, input logic [4:0] src);
    if (!u) return 2'b00;
    if (s.exe_we && s.exe_d != 0 && s.exe_d == src && !s.load) return 2'b10;
    if (s.mem_we && s.mem_d != 0 && s.mem_d == src) return 2'b01;
    return 2'b00;
  endfunction

  // md_left counts the busy cycles still owed, including the done cycle.
  task automatic step();
    logic lu, frz, tmo, stall, busy, done;
    out_t e;
    @(posedge clk);
    md_left  = md_left_n;
    wait_run = wait_run_n;
    #1;
    rst_n = s.rst_n; id_rs = s.rs; id_rt = s.rt; id_use_rs = s.use_rs; id_use_rt = s.use_rt;
    exe_wb_we = s.exe_we; exe_wb_dreg = s.exe_d; exe_is_load = s.load;
    mem_wb_we = s.mem_we; mem_wb_dreg = s.mem_d; branch_taken = s.br;
    md_start = s.start; md_is_div = s.is_div; id_md_read = s.md_read;
    mem_req = s.req; mem_ready = s.rdy;
    if (!s.rst_n) begin
      md_left = 0; wait_run = 0; md_left_n = 0; wait_run_n = 0;
      e = 12'b0011_0000_0000;
    end else begin
      lu    = s.load && s.exe_we && s.exe_d != 0 &&
              ((s.use_rs && s.rs == s.exe_d) || (s.use_rt && s.rt == s.exe_d));
      tmo   = s.req && !s.rdy && wait_run == TMO - 1;
      frz   = s.req && !s.rdy && !tmo;
      busy  = md_left > 0;
      stall = lu || (busy && (s.md_read || s.start));
      done  = !frz && md_left == 1;
      e = {!frz && !stall, !frz && !stall, !frz && !stall && s.br, !frz && stall, !frz,
           ref_fwd(s.use_rs, s.rs), ref_fwd(s.use_rt, s.rt), busy, done, tmo};
      wait_run_n = frz ? wait_run + 1 : 0;
      md_left_n  = frz ? md_left : busy ? md_left - 1 :
                   (s.start && !lu) ? (s.is_div ? DIV : MUL) : 0;
    end
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic idle(input int n);
    s = idle_s();
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin : monitor
    out_t e, got;
    int   c;
    c = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {pc_we, if_id_we, if_id_flush, id_exe_flush, pipe_en,
               fwd_a_sel, fwd_b_sel, md_busy, md_done, mem_err};
        c++;
        n_cmp++;
        if (got !== e) begin
          n_bad++;
          $display("FAIL outputs cycle %0d: got pc/ifw/iff/idf/pipe/fa/fb/busy/done/err=%b expected %b",
                   c, got, e);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    s = idle_s();
    s.rst_n = 0;
    step(); step();
    idle(2);
    // load-use on rs, then the load sits in MEM
    s = idle_s(); s.load = 1; s.exe_we = 1; s.exe_d = 5; s.use_rs = 1; s.rs = 5; step();
    s = idle_s(); s.mem_we = 1; s.mem_d = 5; s.use_rs = 1; s.rs = 5; step();
    // EXE beats MEM, then r0 never forwards
    s = idle_s(); s.exe_we = 1; s.exe_d = 3; s.mem_we = 1; s.mem_d = 3; s.use_rt = 1; s.rt = 3; step();
    s.exe_d = 0; s.mem_d = 0; step();
    // divide with an mflo held behind it
    s = idle_s(); s.start = 1; s.is_div = 1; step();
    s = idle_s(); s.md_read = 1;
    for (int i = 0; i < DIV + 1; i++) step();
    idle(2);
    // freeze three cycles right after a multiply accept
    s = idle_s(); s.start = 1; step();
    s = idle_s(); s.req = 1; s.rdy = 0; step(); step(); step();
    idle(6);
    // timeout
    s = idle_s(); s.req = 1; s.rdy = 0;
    for (int i = 0; i < 2 * TMO + 2; i++) step();
    idle(2);
    // reset in the middle of a divide
    s = idle_s(); s.start = 1; s.is_div = 1; step();
    idle(9);
    s = idle_s(); s.rst_n = 0; step();
    idle(DIV + 4);
    // taken branch during and after a load-use stall
    s = idle_s(); s.load = 1; s.exe_we = 1; s.exe_d = 7; s.use_rt = 1; s.rt = 7; s.br = 1; step();
    s = idle_s(); s.mem_we = 1; s.mem_d = 7; s.use_rt = 1; s.rt = 7; s.br = 1; step();
    idle(2);
    for (int i = 0; i < 4000; i++) begin
      s.rst_n   = $urandom_range(0, 399) != 0;
      s.rs      = 5'($urandom_range(0, 3));
      s.rt      = 5'($urandom_range(0, 3));
      s.exe_d   = 5'($urandom_range(0, 3));
      s.mem_d   = 5'($urandom_range(0, 3));
      s.use_rs  = 1'($urandom_range(0, 1));
      s.use_rt  = 1'($urandom_range(0, 1));
      s.exe_we  = 1'($urandom_range(0, 1));
      s.load    = $urandom_range(0, 3) == 0;
      s.mem_we  = 1'($urandom_range(0, 1));
      s.br      = $urandom_range(0, 3) == 0;
      s.start   = $urandom_range(0, 5) == 0;
      s.is_div  = $urandom_range(0, 3) == 0;
      s.md_read = $urandom_range(0, 4) == 0;
      s.req     = 1'($urandom_range(0, 1));
      s.rdy     = (i % 300 > 270) ? 1'b0 : ($urandom_range(0, 3) != 0);
      step();
    end
    idle(1);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
